// File: rtl/spi_host_ctrl.sv
// SPI initiator for the PSEC5 peripheral: one command sends an address byte plus
// 0-15 data bytes LSB-first, then holds sclk low for an idle gap that the
// peripheral uses as its end-of-message marker. Reads capture miso with a
// configurable pulse lag.
module spi_host_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 32,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic       cmd_read,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned TMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMax + 1);
  // Longest frame is 16 bytes plus the read tail.
  localparam int unsigned PW   = $clog2(129 + RD_LAT);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StGap} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [3:0]    len_q, len_d;
  logic          read_q, read_d;
  logic          err_q, err_d;
  logic [7:0]    rd_sh_q, rd_data_q;
  logic          rd_valid_q;

  logic [PW-1:0] pulse_nx, total, data_bits, cap_lo, cap_idx;
  logic          last_half, gap_end, fall, byte_bound, in_cap;

  assign pulse_nx   = pulse_q + 1'b1;
  assign data_bits  = PW'({len_q, 3'b000});
  assign total      = data_bits + PW'(8) + (read_q ? PW'(RD_LAT) : '0);
  assign last_half  = (timer_q == TW'(CLK_DIV - 1));
  assign gap_end    = (timer_q == TW'(GAP_CYCLES - 1));
  assign fall       = (state_q == StHigh) && last_half;
  // Falling edge that ends bit 7 of a byte and is followed by a data byte.
  assign byte_bound = (pulse_nx[2:0] == 3'b000) && (pulse_nx <= data_bits);
  // Sample at pulse p maps to read data bit p - 8 - RD_LAT.
  assign cap_lo     = PW'(8 + RD_LAT);
  assign cap_idx    = pulse_q - cap_lo;
  assign in_cap     = read_q && (pulse_q >= cap_lo) && (cap_idx < data_bits);

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign sclk      = (state_q == StHigh);
  assign mosi      = shreg_q[0];
  assign err       = err_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

  // Frame sequencing: phase timer, pulse count, mosi shifter and write-byte loading.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    pulse_d  = pulse_q;
    shreg_d  = shreg_q;
    len_d    = len_q;
    read_d   = read_q;
    err_d    = err_q;
    wr_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (cmd_valid) begin
          state_d = StLow;
          pulse_d = '0;
          shreg_d = cmd_addr;
          len_d   = cmd_len;
          read_d  = cmd_read;
          err_d   = 1'b0;
        end
      end
      StLow: begin
        if (last_half) begin
          timer_d = '0;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (last_half) begin
          timer_d = '0;
          pulse_d = pulse_nx;
          state_d = StLow;
          if (pulse_nx == total) begin
            state_d = StGap;
            shreg_d = '0;
          end else if (byte_bound && read_q) begin
            shreg_d = '0;
          end else if (byte_bound) begin
            if (wr_valid) begin
              wr_ready = 1'b1;
              shreg_d  = wr_data;
            end else begin
              // Host underflow: end the frame early with sclk parked low.
              err_d   = 1'b1;
              state_d = StGap;
              shreg_d = '0;
            end
          end else begin
            // After bit 7 this leaves zero, which also covers the read tail.
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      StGap: begin
        if (gap_end) begin
          done    = 1'b1;
          state_d = StIdle;
          timer_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      timer_q <= '0;
      pulse_q <= '0;
      shreg_q <= '0;
      len_q   <= '0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      shreg_q <= shreg_d;
      len_q   <= len_d;
      read_q  <= read_d;
      err_q   <= err_d;
    end
  end

  // Read capture: shift miso in on falling edges, present each completed byte next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_sh_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (fall && in_cap) begin
        rd_sh_q <= {miso, rd_sh_q[7:1]};
        if (cap_idx[2:0] == 3'd7) begin
          rd_data_q  <= {miso, rd_sh_q[7:1]};
          rd_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Bench for spi_host_ctrl: table of frames, a peripheral miso model and a monitor
// that records what appears on the pins; the main process compares against
// expectations built from the command alone.
module tb_spi_host_ctrl;

  localparam int CD  = 2;
  localparam int GAP = 32;
  localparam int RL  = 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       cmd_read = 1'b0;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       cmd_ready, wr_ready, rd_valid, done, err, busy, sclk, mosi;
  logic [7:0] rd_data;
  logic       miso = 1'b0;

  spi_host_ctrl #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .RD_LAT(RL)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_read(cmd_read), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      addr;
    logic [3:0]      len;
    logic            rd;
    logic [2:0][7:0] d;       // data byte k is d[k % 3]
    int              avail;   // write bytes the host offers
    int              pulses;
    int              wrr;
    int              rdv;
    logic            err;
    int              done_ofs; // accept cycle to done cycle
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic [3:0] l, input logic r,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int av, input int p, input int w, input int rv,
                              input logic e, input int ofs);
    vec_t v;
    v.addr = a; v.len = l; v.rd = r; v.d[0] = b0; v.d[1] = b1; v.d[2] = b2;
    v.avail = av; v.pulses = p; v.wrr = w; v.rdv = rv; v.err = e; v.done_ofs = ofs;
    return v;
  endfunction

  function automatic logic [7:0] byte_of(input logic [2:0][7:0] d, input int k);
    int m;
    m = k % 3;
    return d[m[1:0]];
  endfunction

  // Current frame context, owned by the main process.
  logic            cur_rd = 1'b0;
  logic [3:0]      cur_len = '0;
  logic [2:0][7:0] cur_d = '0;
  int              cur_avail = 0;

  // Host write stream.
  int wr_idx = 0;
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) wr_idx <= 0;
    else if (wr_ready) wr_idx <= wr_idx + 1;
  end
  assign wr_data  = byte_of(cur_d, wr_idx);
  assign wr_valid = !cur_rd && (wr_idx < cur_avail);

  // Monitor and peripheral model; observations restart at every accept.
  int         cyc = 0;
  int         rises = 0, low_run = 0, lr_first = 0, first_rise_cyc = 0;
  int         done_cnt = 0, done_cyc = 0, done_lr = 0, acc_cnt = 0, acc_cyc = 0;
  logic       done_err = 1'b0, sclk_prev = 1'b0;
  logic       obs_mosi[$];
  int         obs_wrr[$];
  logic [7:0] obs_rd[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int         idx;
    logic [7:0] b;
    if (sclk && !sclk_prev) begin
      if (rises == 0) begin
        first_rise_cyc = cyc;
        lr_first       = low_run;
      end
      rises = rises + 1;
      obs_mosi.push_back(mosi);
      // Peripheral drives data bit i for the sample at pulse 8 + RL + i.
      idx = rises - 1 - 8 - RL;
      if (cur_rd && idx >= 0 && idx < 8 * int'(cur_len)) begin
        b    = byte_of(cur_d, idx / 8);
        miso = b[idx[2:0]];
      end else begin
        miso = 1'b0;
      end
    end
    if (sclk) low_run = 0;
    else low_run = low_run + 1;
    sclk_prev = sclk;
    if (wr_ready) obs_wrr.push_back(rises - 1);
    if (rd_valid) obs_rd.push_back(rd_data);
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_err = err;
      done_lr  = low_run;
    end
    if (cmd_valid && cmd_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_cyc = cyc;
      rises   = 0;
      obs_mosi.delete();
      obs_wrr.delete();
      obs_rd.delete();
    end
  end

  int         n_vec = 0, n_fail = 0;
  logic       exp_mosi[$];
  int         exp_wrr[$];
  logic [7:0] exp_rd[$];
  vec_t       tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a command and build the expected pin activity from the command alone.
  task automatic start_frame(input vec_t v, input bit hold);
    logic [7:0] b;
    @(posedge clk); #1;
    cur_rd = v.rd; cur_len = v.len; cur_d = v.d; cur_avail = v.avail;
    cmd_addr = v.addr; cmd_len = v.len; cmd_read = v.rd; cmd_valid = 1'b1;
    exp_mosi.delete(); exp_wrr.delete(); exp_rd.delete();
    for (int i = 0; i < 8; i++) exp_mosi.push_back(v.addr[i]);
    for (int k = 0; k < int'(v.len); k++) begin
      b = byte_of(v.d, k);
      if (v.rd) begin
        for (int i = 0; i < 8; i++) exp_mosi.push_back(1'b0);
        exp_rd.push_back(b);
      end else begin
        if (k >= v.avail) break;
        exp_wrr.push_back(8 * k + 7);
        for (int i = 0; i < 8; i++) exp_mosi.push_back(b[i]);
      end
    end
    if (v.rd) for (int i = 0; i < RL; i++) exp_mosi.push_back(1'b0);
    if (!hold) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
    end
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) break;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_frame(input vec_t v);
    chk("pulses", rises, v.pulses);
    chk("mosi_len", obs_mosi.size(), exp_mosi.size());
    for (int i = 0; i < exp_mosi.size() && i < obs_mosi.size(); i++)
      chk("mosi_bit", obs_mosi[i], exp_mosi[i]);
    chk("wr_ready_cnt", obs_wrr.size(), v.wrr);
    for (int i = 0; i < exp_wrr.size() && i < obs_wrr.size(); i++)
      chk("wr_ready_pulse", obs_wrr[i], exp_wrr[i]);
    chk("rd_valid_cnt", obs_rd.size(), v.rdv);
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      chk("rd_data", obs_rd[i], exp_rd[i]);
    chk("done_offset", done_cyc - acc_cyc, v.done_ofs);
    chk("done_err", done_err, v.err);
    chk("first_rise", first_rise_cyc - acc_cyc, 1 + CD);
    chk("gap_low", done_lr, GAP);
  endtask

  task automatic run_vec(input vec_t v);
    start_frame(v, 1'b0);
    wait_done();
    check_frame(v);
    @(negedge clk); #1;
    chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int   d0, a0, d1;
    vec_t v;
    //            addr   len  rd    d0     d1     d2   avail pul wrr rdv err ofs
    tbl[0] = mk(8'h01, 4'd3,  1'b0, 8'hA5, 8'h3C, 8'hFF, 3,  32,  3, 0, 1'b0, 160);
    tbl[1] = mk(8'h3D, 4'd2,  1'b1, 8'h81, 8'h7E, 8'h00, 0,  25,  0, 2, 1'b0, 132);
    tbl[2] = mk(8'h10, 4'd2,  1'b0, 8'h11, 8'h22, 8'h33, 1,  16,  1, 0, 1'b1,  96);
    tbl[3] = mk(8'h02, 4'd0,  1'b0, 8'h00, 8'h00, 8'h00, 0,   8,  0, 0, 1'b0,  64);
    tbl[4] = mk(8'h7F, 4'd0,  1'b1, 8'h00, 8'h00, 8'h00, 0,   9,  0, 0, 1'b0,  68);
    tbl[5] = mk(8'h00, 4'd1,  1'b1, 8'hC3, 8'h00, 8'h00, 0,  17,  0, 1, 1'b0, 100);
    tbl[6] = mk(8'h80, 4'd15, 1'b0, 8'h5A, 8'h01, 8'hF0, 15, 128, 15, 0, 1'b0, 544);

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Reset at pulse 10 of a read: pins drop at once and the frame never completes.
    start_frame(tbl[1], 1'b0);
    for (int n = 0; n < 400 && rises < 11; n++) begin
      @(negedge clk); #1;
    end
    chk("rst_mid_reached", rises, 11);
    chk("rst_mid_sclk_hi", sclk, 1);
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    chk("rst_mid_sclk", sclk, 0);
    chk("rst_mid_mosi", mosi, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt, d0);
    run_vec(tbl[0]);

    // Back-to-back with cmd_valid held: next accept is the cycle after done.
    v = mk(8'h5A, 4'd1, 1'b0, 8'h96, 8'h00, 8'h00, 1, 16, 1, 0, 1'b0, 96);
    start_frame(v, 1'b1);
    wait_done();
    check_frame(v);
    d1 = done_cyc;
    a0 = acc_cnt;
    for (int n = 0; n < 10 && acc_cnt == a0; n++) begin
      @(negedge clk); #1;
    end
    chk("b2b_accept_cyc", acc_cyc, d1 + 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();
    check_frame(v);
    chk("b2b_gap_ge", (lr_first >= GAP) ? 1 : 0, 1);
    chk("b2b_accepts", acc_cnt - a0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
